seven_segment_scanner: RTL

Time-multiplexed, parametrised hex display driver for the board's common-anode seven-segment bank. It latches a 4*DIGITS-bit value and scans one digit per prescaler period over shared segment lines. Per-digit anodes are one-hot. It adds leading-zero blanking, whole-display blink, inter-digit dead time and a frame pulse. It sits between processor debug/status registers and the board display pins.

---
 rtl/seven_segment_scanner.sv | 138 +++++++++++++
 1 files changed

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed hex driver for a common-anode seven-segment bank.
// Scans one digit per prescaler period with dead time, blanking, blink and a frame pulse.
module seven_segment_scanner #(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_pulse
);

  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [6:0]        SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [DW-1:0]     disp_reg, disp_d;
  logic [PW-1:0]     prescaler, prescaler_d;
  logic [IW-1:0]     idx, idx_d;
  logic [BW-1:0]     blink_cnt, blink_cnt_d;
  logic              blink_phase, blink_phase_d;
  logic              dead, dead_d;
  logic              armed, armed_d;
  logic              frame_d;
  logic [6:0]        seg_d;
  logic [DIGITS-1:0] an_d;

  logic              tick, slot, wrap, blanked, off;
  logic [DW-1:0]     upper;
  logic [6:0]        seg_hi, seg_act;
  logic [DIGITS-1:0] an_act;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  // Next-state and output decode; a slot advance is suppressed while dead is
  // high so that CLK_DIV=1 alternates dead and lit cycles.
  always_comb begin
    disp_d        = disp_reg;
    prescaler_d   = prescaler;
    idx_d         = idx;
    blink_cnt_d   = blink_cnt;
    blink_phase_d = blink_phase;
    dead_d        = 1'b0;
    armed_d       = armed;
    frame_d       = 1'b0;

    tick = (prescaler == PW'(CLK_DIV - 1));
    slot = tick && !dead;
    wrap = slot && (idx == IW'(DIGITS - 1));

    if (load) disp_d = in;
    prescaler_d = tick ? '0 : prescaler + PW'(1);

    if (slot) begin
      idx_d   = wrap ? '0 : idx + IW'(1);
      dead_d  = 1'b1;
      armed_d = 1'b1;
    end

    if (wrap) begin
      frame_d = 1'b1;
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase;
      end else begin
        blink_cnt_d = blink_cnt + BW'(1);
      end
    end

    // Nibbles idx..DIGITS-1 shifted down; all-zero means a leading zero.
    upper   = disp_reg >> {idx, 2'b00};
    seg_hi  = hex_to_seg(upper[3:0]);
    blanked = blank_lz && (idx != '0) && (upper == '0);
    off     = !armed || dead || (blink_en && blink_phase);

    seg_act = (off || blanked) ? 7'h00 : seg_hi;
    an_act  = off ? '0 : (DIGITS'(1) << idx);

    seg_d = (ACTIVE_LOW != 0) ? ~seg_act : seg_act;
    an_d  = (ACTIVE_LOW != 0) ? ~an_act  : an_act;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      disp_reg    <= '0;
      prescaler   <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      dead        <= 1'b0;
      armed       <= 1'b0;
      frame_pulse <= 1'b0;
      seg_out     <= SEG_OFF;
      an_out      <= AN_OFF;
    end else begin
      disp_reg    <= disp_d;
      prescaler   <= prescaler_d;
      idx         <= idx_d;
      blink_cnt   <= blink_cnt_d;
      blink_phase <= blink_phase_d;
      dead        <= dead_d;
      armed       <= armed_d;
      frame_pulse <= frame_d;
      seg_out     <= seg_d;
      an_out      <= an_d;
    end
  end

endmodule
